// File: rtl/pkt_rr_arbiter.sv
// pkt_rr_arbiter: packet-level round-robin arbiter sharing one 16-bit
// stream input of the nibble packer between NUM_REQ upstream sources.
// A grant is held from the first beat of a packet until its s_last beat.
// Optional macro ARB_KEEP_CHECK_EN: beats with keep outside {0,4,8,12,16}
// are consumed but not forwarded, and keep_err pulses for one cycle.
module pkt_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int KEEP_W  = 8,
  parameter int IDX_W   = 2
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic [NUM_REQ*DATA_W-1:0] s_data,
  input  logic [NUM_REQ*KEEP_W-1:0] s_keep,
  input  logic [NUM_REQ-1:0]        s_valid,
  input  logic [NUM_REQ-1:0]        s_last,
  output logic [NUM_REQ-1:0]        s_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic [KEEP_W-1:0]         m_keep,
  output logic                      m_valid,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      busy,
  output logic                      keep_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W:0]     cand;
  logic [IDX_W-1:0]   rr_next;
  logic [DATA_W-1:0]  g_data;
  logic [KEEP_W-1:0]  g_keep;
  logic               g_valid;
  logic               g_last;
  logic               busy_w;
  logic               fwd_ok;
  logic               xfer_last;

`ifdef ARB_KEEP_CHECK_EN
  logic keep_err_q;

  // keep counts valid data bits in whole nibbles, so only 0/4/8/12/16 are legal
  function automatic logic keep_legal(input logic [KEEP_W-1:0] k);
    return (k == KEEP_W'(0)) || (k == KEEP_W'(4)) || (k == KEEP_W'(8)) ||
           (k == KEEP_W'(12)) || (k == KEEP_W'(16));
  endfunction

  assign fwd_ok   = keep_legal(g_keep);
  assign keep_err = keep_err_q;
`else
  assign fwd_ok   = 1'b1;
  assign keep_err = 1'b0;
`endif

  assign busy_w    = (state_q == BUSY);
  assign busy      = busy_w;
  assign grant_idx = grant_q;
  assign xfer_last = busy_w & g_valid & m_ready & g_last;
  assign rr_next   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  // Scanning offsets from high to low lets the smallest offset win.
  always_comb begin
    pick_idx = '0;
    cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (s_valid[cand[IDX_W-1:0]]) pick_idx = cand[IDX_W-1:0];
    end
  end

  // Select the granted requester's stream fields.
  always_comb begin
    g_data  = '0;
    g_keep  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_W'(i)) begin
        g_data  = s_data[i*DATA_W +: DATA_W];
        g_keep  = s_keep[i*KEEP_W +: KEEP_W];
        g_valid = s_valid[i];
        g_last  = s_last[i];
      end
    end
  end

  // Zero-latency pass-through while BUSY; everything quiet in IDLE.
  always_comb begin
    m_data  = busy_w ? g_data : '0;
    m_keep  = busy_w ? g_keep : '0;
    m_valid = busy_w & g_valid & fwd_ok;
    m_last  = busy_w & g_last & fwd_ok;
    s_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_ready[i] = busy_w & (grant_q == IDX_W'(i)) & m_ready;
    end
  end

  // Arbitration FSM: grant in IDLE, release on the transferring last beat.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
`ifdef ARB_KEEP_CHECK_EN
      keep_err_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_KEEP_CHECK_EN
      keep_err_q <= busy_w & g_valid & m_ready & ~fwd_ok;
`endif
      case (state_q)
        IDLE: begin
          if (|s_valid) begin
            grant_q <= pick_idx;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (xfer_last) begin
            state_q  <= IDLE;
            rr_ptr_q <= rr_next;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Testbench for pkt_rr_arbiter: per-requester source queues, an expected-beat
// scoreboard filled as stimulus is queued, and checks at the falling edge.
module tb_pkt_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int KEEP_W  = 8;
  localparam int IDX_W   = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [IDX_W-1:0]  src;
  } beat_t;

  logic                      clk = 1'b0;
  logic                      arst;
  logic [NUM_REQ*DATA_W-1:0] s_data;
  logic [NUM_REQ*KEEP_W-1:0] s_keep;
  logic [NUM_REQ-1:0]        s_valid;
  logic [NUM_REQ-1:0]        s_last;
  logic [NUM_REQ-1:0]        s_ready;
  logic [DATA_W-1:0]         m_data;
  logic [KEEP_W-1:0]         m_keep;
  logic                      m_valid;
  logic                      m_last;
  logic                      m_ready;
  logic [IDX_W-1:0]          grant_idx;
  logic                      busy;
  logic                      keep_err;

  pkt_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .KEEP_W(KEEP_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .arst(arst), .s_data(s_data), .s_keep(s_keep), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .m_data(m_data), .m_keep(m_keep),
    .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .grant_idx(grant_idx),
    .busy(busy), .keep_err(keep_err)
  );

  always #5 clk = ~clk;

  beat_t             src_q[NUM_REQ][$];
  beat_t             exp_q[$];
  logic              rdy_pat[$];
  int                xcyc[$];
  logic [NUM_REQ-1:0] hold;
  logic [NUM_REQ-1:0] xfer;
  logic              prev_last;
  int                cyc;
  int                err_seen;
  int                n_checks;
  int                n_errs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic send(input int r, input logic [15:0] d, input logic [7:0] k,
                      input logic l, input bit expect_out);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    b.src  = IDX_W'(r);
    src_q[r].push_back(b);
    if (expect_out) exp_q.push_back(b);
  endtask

  task automatic drive();
    m_ready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hold[i] && src_q[i].size() > 0) begin
        s_valid[i]                  = 1'b1;
        s_data[i*DATA_W +: DATA_W]  = src_q[i][0].data;
        s_keep[i*KEEP_W +: KEEP_W]  = src_q[i][0].keep;
        s_last[i]                   = src_q[i][0].last;
      end else begin
        s_valid[i]                  = 1'b0;
        s_data[i*DATA_W +: DATA_W]  = '0;
        s_keep[i*KEEP_W +: KEEP_W]  = '0;
        s_last[i]                   = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    beat_t e;
    logic [NUM_REQ-1:0] rdy_exp;
    xfer = s_valid & s_ready;
    if (prev_last) check("bubble", {30'd0, busy, m_valid}, 32'd0);
    rdy_exp = busy ? (NUM_REQ'(m_ready) << grant_idx) : '0;
    check("s_ready", 32'(s_ready), 32'(rdy_exp));
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q[0];
        check("data", 32'(m_data), 32'(e.data));
        check("keep", 32'(m_keep), 32'(e.keep));
        check("last", 32'(m_last), 32'(e.last));
        check("src", 32'(grant_idx), 32'(e.src));
        if (m_ready) begin
          void'(exp_q.pop_front());
          xcyc.push_back(cyc);
        end
      end
    end
    prev_last = m_valid & m_ready & m_last;
    if (keep_err === 1'b1) err_seen++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (xfer[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  function automatic bit pending();
    bit p = (exp_q.size() != 0) || (busy === 1'b1);
    for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string tag, input int max_cyc);
    int n = 0;
    while (pending() && n < max_cyc) begin
      step();
      n++;
    end
    if (n >= max_cyc) check({tag, "_timeout"}, 32'(n), 32'(max_cyc - 1));
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_grant"}, 32'(grant_idx), 32'd0);
    check({tag, "_mvalid"}, 32'(m_valid), 32'd0);
    check({tag, "_mlast"}, 32'(m_last), 32'd0);
    check({tag, "_mdata"}, 32'(m_data), 32'd0);
    check({tag, "_mkeep"}, 32'(m_keep), 32'd0);
    check({tag, "_keep_err"}, 32'(keep_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errs = 0; cyc = 0; err_seen = 0;
    hold = '0; xfer = '0; prev_last = 1'b0;
    arst = 1'b1; m_ready = 1'b1;
    s_valid = '0; s_last = '0; s_data = '0; s_keep = '0;

    // Reset state
    step(); step();
    check_idle_outputs("reset");
    arst = 1'b0;

    // Single 3-beat packet from requester 1
    send(1, 16'h1234, 8'd16, 1'b0, 1'b1);
    send(1, 16'h5678, 8'd16, 1'b0, 1'b1);
    send(1, 16'h00AB, 8'd8,  1'b1, 1'b1);
    step();
    check("t1_idle_busy", 32'(busy), 32'd0);
    step();
    check("t1_grant", 32'(grant_idx), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    drain("t1", 20);
    check("t1_busy_after", 32'(busy), 32'd0);

    // rr_ptr should now be 2: with 0 and 3 both valid, 3 is served first
    send(3, 16'h3333, 8'd16, 1'b1, 1'b1);
    send(0, 16'h0000, 8'd4,  1'b1, 1'b1);
    drain("rrptr", 20);

    // Continuous 1-beat packets from all requesters after a fresh reset
    arst = 1'b1; step(); arst = 1'b0;
    check("t2_reset_grant", 32'(grant_idx), 32'd0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++)
        send(i, 16'(16'hA000 + r*16 + i), 8'd12, 1'b1, 1'b1);
    xcyc.delete();
    drain("t2", 40);
    check("t2_count", 32'(xcyc.size()), 32'd8);
    for (int i = 1; i < xcyc.size(); i++) check("t2_gap", 32'(xcyc[i] - xcyc[i-1]), 32'd2);

    // Back-pressure on requester 2
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    send(2, 16'hBEEF, 8'd16, 1'b0, 1'b1);
    send(2, 16'hCAFE, 8'd4,  1'b1, 1'b1);
    drain("t3", 20);

    // Requester 0 stalls mid-packet while requester 3 waits
    send(0, 16'h0101, 8'd16, 1'b0, 1'b1);
    send(0, 16'h0202, 8'd16, 1'b0, 1'b1);
    send(0, 16'h0303, 8'd8,  1'b1, 1'b1);
    step(); step();
    hold[0] = 1'b1;
    send(3, 16'h3030, 8'd16, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_grant_held", 32'(grant_idx), 32'd0);
      check("t4_mvalid_low", 32'(m_valid), 32'd0);
      check("t4_busy", 32'(busy), 32'd1);
    end
    hold[0] = 1'b0;
    drain("t4", 20);

    // Reset in the middle of a 4-beat packet, then re-send it intact
    for (int i = 0; i < 4; i++) send(1, 16'(16'h1100 + i), 8'd16, (i == 3), 1'b1);
    step(); step(); step();
    arst = 1'b1;
    src_q[1].delete();
    exp_q.delete();
    step();
    check_idle_outputs("t5_reset");
    check("t5_sready", 32'(s_ready), 32'd0);
    arst = 1'b0;
    for (int i = 0; i < 4; i++) send(1, 16'(16'h2200 + i), 8'd16, (i == 3), 1'b1);
    drain("t5", 20);

    // Illegal keep mid-packet and keep=0 on the last beat
    send(3, 16'hAAAA, 8'd16, 1'b0, 1'b1);
`ifdef ARB_KEEP_CHECK_EN
    send(3, 16'hBBBB, 8'd5,  1'b0, 1'b0);
`else
    send(3, 16'hBBBB, 8'd5,  1'b0, 1'b1);
`endif
    send(3, 16'hCCCC, 8'd0,  1'b1, 1'b1);
    drain("t6", 20);
    step();
    check("t6_idle", 32'(busy), 32'd0);
`ifdef ARB_KEEP_CHECK_EN
    check("keep_err_pulses", 32'(err_seen), 32'd1);
`else
    check("keep_err_pulses", 32'(err_seen), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/pkt_rr_arbiter.md
Name: pkt_rr_arbiter

Overview:
- Packet-level round-robin arbiter. Shares one downstream nibble-packer stream input between NUM_REQ upstream 16-bit AXI-Stream-style sources.
- A grant is held for a whole packet, from first beat to the beat carrying s_last.
- The block sits directly in front of the packer and reuses its keep encoding: keep = number of valid data bits, legal values 0/4/8/12/16.

Parameters:
- NUM_REQ, 4, number of upstream requesters (2..8).
- DATA_W, 16, data width per stream.
- KEEP_W, 8, keep field width per stream.
- IDX_W, 2, grant index width; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- arst  input  1  reset, synchronous, active-high.
- s_data  input  NUM_REQ*DATA_W  requester data; requester i occupies bits [i*DATA_W +: DATA_W].
- s_keep  input  NUM_REQ*KEEP_W  requester keep, packed the same way.
- s_valid  input  NUM_REQ  per-requester valid.
- s_last  input  NUM_REQ  per-requester end of packet.
- s_ready  output  NUM_REQ  per-requester ready.
- m_data  output  DATA_W  to packer.
- m_keep  output  KEEP_W  to packer.
- m_valid  output  1  to packer.
- m_last  output  1  to packer.
- m_ready  input  1  from packer.
- grant_idx  output  IDX_W  currently or last granted requester.
- busy  output  1  high while a packet is in flight.
- keep_err  output  1  one-cycle error pulse (only with the optional feature; tied 0 otherwise).

Behaviour:
- Reset (arst=1 at a clock edge):
  - state=IDLE, rr_ptr=0, grant_idx=0, busy=0, keep_err=0.
  - All s_ready=0, m_valid=0, m_last=0, m_data=0, m_keep=0.
  - Reset mid-packet abandons the packet: no m_last is generated. The source must restart its packet after reset.
- States: IDLE, BUSY.
- IDLE:
  - All s_ready=0. m_valid=0, m_data/m_keep/m_last=0.
  - If any s_valid is high, pick the first requester with s_valid=1 searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register it into grant_idx; next state=BUSY, busy=1.
  - If no s_valid is high, stay in IDLE.
- BUSY: combinational pass-through of the granted requester g=grant_idx.
  - m_data/m_keep/m_last/m_valid = requester g's fields.
  - s_ready[g]=m_ready; s_ready of every other requester=0.
  - A beat transfers when s_valid[g] & m_ready.
- Leaving BUSY:
  - On a transferring beat with s_last[g]=1: next state=IDLE, busy=0, rr_ptr=(g+1) mod NUM_REQ.
  - grant_idx holds its value in IDLE.
- Latency:
  - 1 cycle from first s_valid in IDLE to first possible transfer.
  - 0 cycles in-packet.
  - 1 mandatory idle bubble between consecutive packets, even from different requesters.
- Grant stability:
  - A granted requester dropping s_valid mid-packet does not release the grant. The arbiter waits indefinitely; m_valid=0 meanwhile.
  - m_ready low stalls the beat; all master outputs track the granted source unchanged.
- Fairness:
  - With all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
  - No requester waits more than NUM_REQ-1 packets.
- Keep with zero data bits (keep=0):
  - Forwarded as an ordinary beat. The packer treats it as an empty beat.
  - keep=0 with s_last ends the packet normally.
- Simultaneous events: a requester asserting s_valid on the same edge the current packet's last beat transfers is considered in the following IDLE cycle, using the updated rr_ptr.

Optional Feature:
- Macro: ARB_KEEP_CHECK_EN.
- Defined:
  - In BUSY, a granted-source beat whose keep is not in {0,4,8,12,16} is consumed (s_ready[g]=m_ready) but not forwarded: m_valid=0 that cycle.
  - keep_err pulses high for exactly one cycle, registered, in the cycle after the beat.
  - If that beat carried s_last, the packet still terminates (return to IDLE, rr_ptr advances). The packer sees no m_last for that packet.
- Undefined: keep is forwarded unchecked; keep_err is tied 0.

Test Plan:
- Reset, then requester 1 sends 3 beats: keep=16,16,8, data 0x1234,0x5678,0x00AB, last on beat 3, m_ready=1.
  - Expect grant_idx=1 one cycle after s_valid.
  - Expect 3 m_valid beats with identical data/keep and m_last on beat 3.
  - Expect busy=0 and rr_ptr=2 afterwards.
- All 4 requesters valid with 1-beat packets continuously → grant order 0,1,2,3,0; one idle cycle between packets.
- Requester 2 granted; m_ready toggles 1,0,0,1 → beat held stable during stall; s_ready[2] follows m_ready; other s_ready=0 throughout.
- Requester 0 granted, drops s_valid for 5 cycles mid-packet while requester 3 is valid → grant stays 0; requester 3 served only after requester 0's last beat.
- Assert arst mid-packet on beat 2 of 4 → next cycle all outputs 0, state IDLE, grant_idx=0. Re-sent packet is passed through intact.
- With ARB_KEEP_CHECK_EN: beat keep=5 within a 3-beat packet → that beat consumed, not forwarded; keep_err high one cycle; remaining beats forwarded.
